muldiv_unit: RTL and testbench

//  Iterative RV32M multiply/divide execution unit for the E stage of the 5-stage pipeline.

---
 rtl/muldiv_unit_if.sv | 25 ++
 rtl/muldiv_unit.sv | 158 +++++++++++++++
 tb/tb_muldiv_unit.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: request/response bundle between the E stage and muldiv_unit.
//   master (E stage):  drives start, funct3, op_a, op_b, flush; observes busy, done, result
//   slave  (unit):     observes the request side; drives busy, done, result
interface muldiv_unit_if #(
    parameter int unsigned XLEN = 32
);
    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            flush;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, funct3, op_a, op_b, flush,
        input  busy, done, result
    );

    modport slave (
        input  start, funct3, op_a, op_b, flush,
        output busy, done, result
    );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit (radix-2, one step per cycle).
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    slave side of muldiv_unit_if:
//            start/funct3/op_a/op_b  request, accepted only in IDLE without flush
//            flush                   abort the op in flight, result untouched
//            busy                    op in flight (CALC or FIN)
//            done/result             one-cycle done pulse; result holds until next done
module muldiv_unit #(
    parameter int unsigned XLEN     = 32,
    parameter bit          FAST_MUL = 1'b0
) (
    input  logic          clk,
    input  logic          rst_n,
    muldiv_unit_if.slave  bus
);
    localparam int unsigned CntW = $clog2(XLEN + 1);

    typedef enum logic [1:0] {StIdle, StCalc, StFin} state_e;

    state_e              state_q, state_d;
    logic [2:0]          funct3_q, funct3_d;
    logic [XLEN-1:0]     mag_b_q, mag_b_d;
    logic                neg_q, neg_d;
    logic [CntW-1:0]     counter_q, counter_d;
    // Shared accumulator: mul = {high, low} product; div = {remainder, quotient}.
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [XLEN-1:0]     result_q, result_d;

    // Operand decode at accept time
    logic            signed_a, signed_b, sign_a, sign_b, is_div;
    logic [XLEN-1:0] mag_a, mag_b;
    logic            div_zero, div_ovf;

    always_comb begin
        is_div   = bus.funct3[2];
        signed_a = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b010) ||
                   (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110);
        signed_b = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b100) ||
                   (bus.funct3 == 3'b110);
        sign_a   = signed_a & bus.op_a[XLEN-1];
        sign_b   = signed_b & bus.op_b[XLEN-1];
        mag_a    = sign_a ? -bus.op_a : bus.op_a;
        mag_b    = sign_b ? -bus.op_b : bus.op_b;
        div_zero = (bus.op_b == '0);
        div_ovf  = signed_a && (bus.op_a == {1'b1, {(XLEN-1){1'b0}}}) && (bus.op_b == '1);
    end

    // One iteration of each algorithm
    logic [XLEN:0]       mul_sum, div_top, div_diff;
    logic [2*XLEN-1:0]   mul_next, div_next;

    always_comb begin
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mag_b_q} : '0);
        mul_next = {mul_sum, acc_q[XLEN-1:1]};
        div_top  = acc_q[2*XLEN-1:XLEN-1];
        div_diff = div_top - {1'b0, mag_b_q};
        // Restoring step: keep the subtraction only if it did not borrow
        if (!div_diff[XLEN]) begin
            div_next = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        end else begin
            div_next = {acc_q[2*XLEN-2:0], 1'b0};
        end
    end

    // Sign correction and output select. Mul negates the full product so the
    // high half is correct; div negates quotient or remainder on its own.
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   mul_res, div_sel, div_res, fin_val;

    always_comb begin
        prod    = neg_q ? -acc_q : acc_q;
        mul_res = (funct3_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        div_sel = funct3_q[1] ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
        div_res = neg_q ? -div_sel : div_sel;
        fin_val = funct3_q[2] ? div_res : mul_res;
    end

    always_comb begin
        state_d   = state_q;
        funct3_d  = funct3_q;
        mag_b_d   = mag_b_q;
        neg_d     = neg_q;
        counter_d = counter_q;
        acc_d     = acc_q;
        result_d  = result_q;

        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    funct3_d  = bus.funct3;
                    mag_b_d   = mag_b;
                    counter_d = CntW'(XLEN);
                    acc_d     = {{XLEN{1'b0}}, mag_a};
                    neg_d     = (bus.funct3[2] && bus.funct3[1]) ? sign_a : (sign_a ^ sign_b);
                    state_d   = StCalc;
                    // Early results are loaded so that FIN's normal select yields them
                    if (is_div && div_zero) begin
                        neg_d   = 1'b0;
                        acc_d   = {bus.op_a, {XLEN{1'b1}}};
                        state_d = StFin;
                    end else if (is_div && div_ovf) begin
                        neg_d   = 1'b0;
                        acc_d   = {{XLEN{1'b0}}, bus.op_a};
                        state_d = StFin;
                    end else if (FAST_MUL && !is_div) begin
                        acc_d   = {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b};
                        state_d = StFin;
                    end
                end
            end
            StCalc: begin
                counter_d = counter_q - 1'b1;
                acc_d     = funct3_q[2] ? div_next : mul_next;
                if (counter_q == CntW'(1)) begin
                    state_d = StFin;
                end
            end
            StFin: begin
                result_d = fin_val;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (bus.flush) begin
            state_d  = StIdle;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            funct3_q  <= '0;
            mag_b_q   <= '0;
            neg_q     <= 1'b0;
            counter_q <= '0;
            acc_q     <= '0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            funct3_q  <= funct3_d;
            mag_b_q   <= mag_b_d;
            neg_q     <= neg_d;
            counter_q <= counter_d;
            acc_q     <= acc_d;
            result_q  <= result_d;
        end
    end

    // Result is visible in the FIN cycle itself, then held in result_q.
    always_comb begin
        bus.busy   = (state_q != StIdle);
        bus.done   = (state_q == StFin) && !bus.flush;
        bus.result = bus.done ? fin_val : result_q;
    end
endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;
    localparam int unsigned XLEN = 32;

    localparam logic [2:0] F_MUL    = 3'b000;
    localparam logic [2:0] F_MULH   = 3'b001;
    localparam logic [2:0] F_MULHSU = 3'b010;
    localparam logic [2:0] F_MULHU  = 3'b011;
    localparam logic [2:0] F_DIV    = 3'b100;
    localparam logic [2:0] F_DIVU   = 3'b101;
    localparam logic [2:0] F_REM    = 3'b110;
    localparam logic [2:0] F_REMU   = 3'b111;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    muldiv_unit_if #(.XLEN(XLEN)) if0 ();
    muldiv_unit_if #(.XLEN(XLEN)) if1 ();

    muldiv_unit #(.XLEN(XLEN), .FAST_MUL(1'b0)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if0.slave)
    );

    muldiv_unit #(.XLEN(XLEN), .FAST_MUL(1'b1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1.slave)
    );

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one op on the iterative unit; optionally poke a stray start mid-flight.
    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int lat,
                          input int stray);
        int c;
        bit seen;
        logic [31:0] e;
        @(negedge clk);
        if0.start = 1'b1; if0.funct3 = f3; if0.op_a = a; if0.op_b = b;
        exp_q.push_back(exp);
        @(posedge clk); #1;
        if0.start = 1'b0; if0.op_a = ~a; if0.op_b = ~b;
        seen = 1'b0;
        c = 1;
        while (!seen && c <= 60) begin
            if (c == stray) begin
                if0.start = 1'b1; if0.funct3 = F_MUL; if0.op_a = 32'd3; if0.op_b = 32'd3;
            end
            @(negedge clk);
            if (c == 1) check({tag, " busy c1"}, 32'(if0.busy), 32'd1);
            if (if0.done) begin
                seen = 1'b1;
                check({tag, " latency"}, 32'(c), 32'(lat));
                e = exp_q.pop_front();
                check({tag, " result"}, if0.result, e);
            end
            @(posedge clk); #1;
            if0.start = 1'b0;
            c++;
        end
        if (!seen) begin
            check({tag, " done seen"}, 32'(seen), 32'd1);
            void'(exp_q.pop_front());
        end else begin
            @(negedge clk);
            check({tag, " idle after"}, {30'd0, if0.busy, if0.done}, 32'd0);
        end
    endtask

    task automatic fast_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp);
        logic [31:0] e;
        @(negedge clk);
        if1.start = 1'b1; if1.funct3 = f3; if1.op_a = a; if1.op_b = b;
        exp_q.push_back(exp);
        @(posedge clk); #1;
        if1.start = 1'b0;
        @(negedge clk);
        check({tag, " done c1"}, 32'(if1.done), 32'd1);
        e = exp_q.pop_front();
        check({tag, " result"}, if1.result, e);
        @(negedge clk);
        check({tag, " idle after"}, {30'd0, if1.busy, if1.done}, 32'd0);
    endtask

    initial begin
        int pulses;
        if0.start = 1'b0; if0.funct3 = '0; if0.op_a = '0; if0.op_b = '0; if0.flush = 1'b0;
        if1.start = 1'b0; if1.funct3 = '0; if1.op_a = '0; if1.op_b = '0; if1.flush = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset busy", 32'(if0.busy), 32'd0);
        check("reset done", 32'(if0.done), 32'd0);
        check("reset result", if0.result, 32'd0);
        rst_n = 1'b1;

        // Multiplies
        run_op("MUL 7*-3", F_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 0);
        run_op("MULH min*min", F_MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, 0);
        run_op("MULHU max*max", F_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 0);
        run_op("MULHSU -1*2", F_MULHSU, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 33, 0);
        run_op("MULH -5*3", F_MULH, 32'hFFFF_FFFB, 32'd3, 32'hFFFF_FFFF, 33, 0);

        // Early paths
        run_op("DIV 5/0", F_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0);
        run_op("REM 5/0", F_REM, 32'd5, 32'd0, 32'd5, 1, 0);
        run_op("DIVU 9/0", F_DIVU, 32'd9, 32'd0, 32'hFFFF_FFFF, 1, 0);
        run_op("DIV ovf", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
        run_op("REM ovf", F_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 0);

        // Divides
        run_op("DIV -7/2", F_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 0);
        run_op("REM -7/2", F_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 0);
        run_op("DIV 20/-6", F_DIV, 32'd20, 32'hFFFF_FFFA, 32'hFFFF_FFFD, 33, 0);
        run_op("DIVU 100/7 stray start", F_DIVU, 32'd100, 32'd7, 32'd14, 33, 5);
        run_op("REMU 100/7", F_REMU, 32'd100, 32'd7, 32'd2, 33, 0);

        // Flush at cycle 10 of a DIV: no done, idle in cycle 11, result kept at 2
        @(negedge clk);
        if0.start = 1'b1; if0.funct3 = F_DIV; if0.op_a = 32'd1000; if0.op_b = 32'd3;
        @(posedge clk); #1;
        if0.start = 1'b0;
        repeat (9) @(posedge clk);
        #1 if0.flush = 1'b1;
        @(negedge clk);
        check("flush c10 done", 32'(if0.done), 32'd0);
        @(posedge clk); #1;
        if0.flush = 1'b0;
        @(negedge clk);
        check("flush c11 busy", 32'(if0.busy), 32'd0);
        check("flush c11 result", if0.result, 32'd2);
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (if0.done) pulses++;
        end
        check("flush no done", 32'(pulses), 32'd0);

        // Synchronous reset in the middle of CALC
        @(negedge clk);
        if0.start = 1'b1; if0.funct3 = F_MULHU; if0.op_a = 32'hFFFF_FFFF; if0.op_b = 32'd9;
        @(posedge clk); #1;
        if0.start = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        check("pre-reset busy", 32'(if0.busy), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("mid reset outputs", {if0.result[29:0], if0.busy, if0.done}, 32'd0);
        check("mid reset result", if0.result, 32'd0);
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (if0.done) pulses++;
        end
        check("reset no done", 32'(pulses), 32'd0);

        // Single-cycle multiplier build
        fast_op("FAST MUL 6*7", F_MUL, 32'd6, 32'd7, 32'd42);
        fast_op("FAST MULHU", F_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        fast_op("FAST MULH -1*-1", F_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0);

        check("scoreboard drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
